// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter sharing one pipelined float adder among NUM_REQ requesters.
// Optional per-requester saturating grant counters when FP_ADDER_ARB_PERF_EN is defined.
module fp_adder_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADD_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  output logic                   add_valid,
  input  logic [31:0]            add_sum,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_sum,
  output logic                   busy
`ifdef FP_ADDER_ARB_PERF_EN
  ,
  output logic [16*NUM_REQ-1:0]  perf_grants
`endif
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            gnt_any;
  logic [IdxW-1:0] gnt_idx;
  logic [IdxW-1:0] cand_idx;
  int unsigned     cand;

  logic [31:0]     add_a_q, add_a_d, add_b_q, add_b_d;
  logic            add_valid_q, add_valid_d;

  logic [ADD_LATENCY-1:0]           tag_vld_q, tag_vld_d;
  logic [ADD_LATENCY-1:0][IdxW-1:0] tag_idx_q, tag_idx_d;

  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [31:0]        resp_sum_q, resp_sum_d;

  // First valid requester at or after the pointer wins; reset masks every grant.
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand     = (32'(ptr_q) + k) % NUM_REQ;
      cand_idx = IdxW'(cand);
      if (!gnt_any && !rst && req_valid[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d       = ptr_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_valid_d = gnt_any;
    if (gnt_any) begin
      ptr_d   = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + IdxW'(1);
      add_a_d = req_a[32*gnt_idx +: 32];
      add_b_d = req_b[32*gnt_idx +: 32];
    end
  end

  // Tag stage 0 launches alongside add_valid; the last stage lines up with add_sum.
  always_comb begin
    tag_vld_d    = '0;
    tag_idx_d    = '0;
    tag_vld_d[0] = gnt_any;
    tag_idx_d[0] = gnt_idx;
    for (int unsigned i = 1; i < ADD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
  end

  always_comb begin
    resp_valid_d = '0;
    resp_sum_d   = resp_sum_q;
    if (tag_vld_q[ADD_LATENCY-1]) begin
      resp_valid_d[tag_idx_q[ADD_LATENCY-1]] = 1'b1;
      resp_sum_d                             = add_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_valid_q  <= 1'b0;
      tag_vld_q    <= '0;
      tag_idx_q    <= '0;
      resp_valid_q <= '0;
      resp_sum_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_valid_q  <= add_valid_d;
      tag_vld_q    <= tag_vld_d;
      tag_idx_q    <= tag_idx_d;
      resp_valid_q <= resp_valid_d;
      resp_sum_q   <= resp_sum_d;
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_valid  = add_valid_q;
  assign resp_valid = resp_valid_q;
  assign resp_sum   = resp_sum_q;
  assign busy       = add_valid_q | (|tag_vld_q) | (|resp_valid_q);

`ifdef FP_ADDER_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i] && perf_q[i] != 16'hFFFF) perf_d[i] = perf_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_grants = perf_q;
`endif

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter (NUM_REQ=4, ADD_LATENCY=1) with a table-driven adder model.
module tb_fp_adder_arbiter;

  localparam int unsigned N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic [31:0]     add_a, add_b, add_sum;
  logic            add_valid;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_sum;
  logic            busy;
`ifdef FP_ADDER_ARB_PERF_EN
  logic [16*N-1:0] perf_grants;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fp_adder_arbiter #(.NUM_REQ(N), .ADD_LATENCY(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_valid  (add_valid),
    .add_sum    (add_sum),
    .resp_valid (resp_valid),
    .resp_sum   (resp_sum),
    .busy       (busy)
`ifdef FP_ADDER_ARB_PERF_EN
    ,
    .perf_grants(perf_grants)
`endif
  );

  // Known float sums by table; anything else maps to a XOR marker so routing is still checkable.
  function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F99999A && b == 32'h3F8CCCCD) return 32'h40133333;
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40A00000;
    return a ^ b;
  endfunction

  // Single-cycle adder: result presented in the cycle add_valid is high.
  always_comb add_sum = model_sum(add_a, add_b);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rr_a(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] rr_b(input int i);
    return 32'h0000_0B00 << i;
  endfunction

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    #1;
    check("rst_ready",     64'(req_ready),  64'h0);
    check("rst_add_valid", 64'(add_valid),  64'h0);
    check("rst_add_a",     64'(add_a),      64'h0);
    check("rst_resp",      64'(resp_valid), 64'h0);
    check("rst_resp_sum",  64'(resp_sum),   64'h0);
    check("rst_busy",      64'(busy),       64'h0);

    // Single request on requester 0: 1.2 + 1.1
    step();
    rst       = 1'b0;
    req_valid = 4'b0001;
    req_a[31:0] = 32'h3F99999A;
    req_b[31:0] = 32'h3F8CCCCD;
    #1;
    check("single_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    #1;
    check("single_add_valid", 64'(add_valid),  64'h1);
    check("single_add_a",     64'(add_a),      64'h3F99999A);
    check("single_add_b",     64'(add_b),      64'h3F8CCCCD);
    check("single_busy",      64'(busy),       64'h1);
    check("single_no_resp",   64'(resp_valid), 64'h0);
    step();
    check("single_resp",     64'(resp_valid), 64'h1);
    check("single_resp_sum", 64'(resp_sum),   64'h40133333);
    step();
    check("single_resp_gone", 64'(resp_valid), 64'h0);
    check("single_idle",      64'(busy),       64'h0);

    // Pointer is 1: grant 1 alone, moving the pointer to 2
    req_valid = 4'b0010;
    req_a[63:32] = rr_a(1);
    req_b[63:32] = rr_b(1);
    #1;
    check("p1_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = 4'b1010;
    req_a[127:96] = 32'h40000000;
    req_b[127:96] = 32'h40400000;
    #1;
    check("p2_ready_3", 64'(req_ready), 64'h8);
    step();
    req_valid = 4'b0010;
    #1;
    check("p2_ready_1",  64'(req_ready), 64'h2);
    check("p2_add_a",    64'(add_a),     64'h40000000);
    step();
    req_valid = '0;
    #1;
    check("p2_resp3",     64'(resp_valid), 64'h8);
    check("p2_resp3_sum", 64'(resp_sum),   64'h40A00000);
    step();
    check("p2_resp1",     64'(resp_valid), 64'h2);
    check("p2_resp1_sum", 64'(resp_sum),   64'(rr_a(1) ^ rr_b(1)));
    step();

    // Pointer is 2: requesters 0 and 1 go back to back, then reset mid-flight
    req_valid = 4'b0011;
    req_a[31:0] = rr_a(0);
    req_b[31:0] = rr_b(0);
    #1;
    check("rst_mid_g0", 64'(req_ready), 64'h1);
    step();
    #1;
    check("rst_mid_g1", 64'(req_ready), 64'h2);
    step();
    check("rst_mid_inflight", 64'(busy), 64'h1);
    req_valid = '1;
    rst       = 1'b1;
    #1;
    check("rst_mid_resp",  64'(resp_valid), 64'h0);
    check("rst_mid_busy",  64'(busy),       64'h0);
    check("rst_mid_ready", 64'(req_ready),  64'h0);
    check("rst_mid_addv",  64'(add_valid),  64'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = rr_a(i);
      req_b[32*i +: 32] = rr_b(i);
    end

    // All four held valid for 8 cycles from a fresh pointer
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) check($sformatf("rr_grant_%0d", c), 64'(req_ready), 64'(4'b0001 << (c % 4)));
      if (c >= 2) begin
        check($sformatf("rr_resp_%0d", c), 64'(resp_valid), 64'(4'b0001 << ((c - 2) % 4)));
        check($sformatf("rr_sum_%0d", c), 64'(resp_sum),
              64'(rr_a((c - 2) % 4) ^ rr_b((c - 2) % 4)));
      end else begin
        check($sformatf("rr_noresp_%0d", c), 64'(resp_valid), 64'h0);
      end
    end
    step();
    check("rr_tail_resp", 64'(resp_valid), 64'h0);
    check("rr_tail_busy", 64'(busy),       64'h0);

`ifdef FP_ADDER_ARB_PERF_EN
    // Requester 2 alone for 70000 grants saturates its counter
    req_valid = 4'b0100;
    for (int c = 0; c < 70000; c++) step();
    req_valid = '0;
    step();
    check("perf_sat_2", 64'(perf_grants[47:32]), 64'hFFFF);
    check("perf_resp",  64'(resp_valid),         64'h4);
    check("perf_sum",   64'(resp_sum),           64'(rr_a(2) ^ rr_b(2)));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
